// File: rtl/int_to_ieee754.sv
// int_to_ieee754: converts a 16-bit integer sample into an IEEE-754 double.
// The magnitude is normalised one bit per cycle until its leading one reaches
// bit 16. That bit becomes the hidden bit, so the conversion is exact and needs
// no rounding. Both sides use valid/ready handshakes.
module int_to_ieee754 #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] mag_q, mag_d;
  logic [4:0]  e_q, e_d;
  logic        sign_q, sign_d;
  logic [63:0] y_q, y_d;
  logic        out_valid_q, out_valid_d;

  logic        neg_s;
  logic [16:0] x_ext_s;
  logic [16:0] abs_s;
  logic [10:0] exp_s;

  // Sign-extend for signed mode, then negate negatives; 17 bits keep -32768 exact.
  always_comb begin
    neg_s   = SIGNED & x[15];
    x_ext_s = {neg_s, x};
    if (neg_s) begin
      abs_s = 17'd0 - x_ext_s;
    end else begin
      abs_s = x_ext_s;
    end
    exp_s = 11'd1023 + {6'd0, e_q};
  end

  // Next-state and datapath: accept in IDLE, shift in NORM, hold in DONE.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    e_d         = e_q;
    sign_d      = sign_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = neg_s;
          mag_d   = abs_s;
          e_d     = 5'd16;
          state_d = NORM;
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (mag_q == 17'd0) begin
          // Zero is always reported as +0.0.
          y_d         = 64'd0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (mag_q[16]) begin
          y_d         = {sign_q, exp_s, mag_q[15:0], 36'd0};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          mag_d = {mag_q[15:0], 1'b0};
          e_d   = e_q - 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= 17'd0;
      e_q         <= 5'd0;
      sign_q      <= 1'b0;
      y_q         <= 64'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule
